// File: rtl/hssl_lane_manager.sv
// hssl_lane_manager: per-lane GT receive bring-up, alignment and health monitor.
// Each lane runs its own FSM: DISABLED -> RESET -> WAIT_DONE -> ALIGN -> UP,
// with RETRY on timeout/error bursts and FAILED after MAX_RETRIES retries.
// Ports:
//   rx_usrclk2_in          clock; every input is synchronous to it
//   reset_all_in           synchronous active-high reset
//   lane_enable_in         per-lane enable
//   rx_reset_done_in       GT rx reset done per lane
//   rx_commadet_in         comma detected this cycle per lane
//   rx_disperr_in          per-byte disparity error, 4 bits per lane
//   rx_encerr_in           per-byte not-in-table error, 4 bits per lane
//   rx_bufstatus_in        elastic buffer over/underflow per lane
//   err_clear_in           zeroes all error counters
//   rx_reset_datapath_out  GT rx datapath reset per lane
//   lane_up_out            lane aligned and healthy
//   lane_failed_out        lane gave up
//   link_up_out            all enabled lanes up, at least one enabled
//   err_count_out          saturating UP error-cycle count, lane i at [i*CNT_W +: CNT_W]
module hssl_lane_manager #(
   parameter int NUM_LANES     = 4,
   parameter int ALIGN_COMMAS  = 16,
   parameter int ALIGN_TIMEOUT = 65535,
   parameter int RESET_PULSE   = 8,
   parameter int ERR_WINDOW    = 1024,
   parameter int ERR_THRESHOLD = 8,
   parameter int MAX_RETRIES   = 7,
   parameter int CNT_W         = 16
) (
   input  logic                       rx_usrclk2_in,
   input  logic                       reset_all_in,
   input  logic [NUM_LANES-1:0]       lane_enable_in,
   input  logic [NUM_LANES-1:0]       rx_reset_done_in,
   input  logic [NUM_LANES-1:0]       rx_commadet_in,
   input  logic [4*NUM_LANES-1:0]     rx_disperr_in,
   input  logic [4*NUM_LANES-1:0]     rx_encerr_in,
   input  logic [NUM_LANES-1:0]       rx_bufstatus_in,
   input  logic                       err_clear_in,
   output logic [NUM_LANES-1:0]       rx_reset_datapath_out,
   output logic [NUM_LANES-1:0]       lane_up_out,
   output logic [NUM_LANES-1:0]       lane_failed_out,
   output logic                       link_up_out,
   output logic [CNT_W*NUM_LANES-1:0] err_count_out
);

   typedef enum logic [2:0] {
      ST_DISABLED,
      ST_RESET,
      ST_WAIT_DONE,
      ST_ALIGN,
      ST_UP,
      ST_RETRY,
      ST_FAILED
   } lane_state_t;

   localparam int TMR_MAX = (ALIGN_TIMEOUT > RESET_PULSE) ?
                            ALIGN_TIMEOUT : RESET_PULSE;
   localparam int TMR_W = $clog2(TMR_MAX + 1);
   localparam int CC_W  = $clog2(ALIGN_COMMAS + 1);
   localparam int WIN_W = $clog2(ERR_WINDOW + 1);
   localparam int EC_W  = $clog2(ERR_THRESHOLD + 1);
   localparam int RTY_W = $clog2(MAX_RETRIES + 1);

   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(RESET_PULSE - 1);
   localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(ALIGN_TIMEOUT - 1);
   localparam logic [CC_W-1:0]  COMMA_LAST = CC_W'(ALIGN_COMMAS - 1);
   localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(ERR_WINDOW - 1);
   localparam logic [EC_W-1:0]  THR_LAST   = EC_W'(ERR_THRESHOLD - 1);
   localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRIES);

   logic [NUM_LANES-1:0] up_now;
   logic                 link_q;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_state_t      st_q, st_d;
      logic [TMR_W-1:0] tmr_q, tmr_d;
      logic [RTY_W-1:0] rty_q, rty_d;
      logic [CC_W-1:0]  cc_q, cc_d;
      logic [WIN_W-1:0] win_q, win_d;
      logic [EC_W-1:0]  ec_q, ec_d;
      logic [CNT_W-1:0] cnt_q;
      logic             rst_q, up_q, fail_q;
      logic             en, err, comma;

      assign en    = lane_enable_in[i];
      assign comma = rx_commadet_in[i];
      assign err   = (|(rx_disperr_in[4*i +: 4] | rx_encerr_in[4*i +: 4]))
                   | rx_bufstatus_in[i];

      always_comb begin
         st_d  = st_q;
         tmr_d = tmr_q;
         rty_d = rty_q;
         cc_d  = cc_q;
         win_d = win_q;
         ec_d  = ec_q;
         if (!en) begin
            st_d  = ST_DISABLED;
            tmr_d = '0;
            rty_d = '0;
            cc_d  = '0;
            win_d = '0;
            ec_d  = '0;
         end else begin
            unique case (st_q)
               ST_DISABLED: begin
                  st_d  = ST_RESET;
                  tmr_d = '0;
                  rty_d = '0;
               end
               ST_RESET: begin
                  if (tmr_q == PULSE_LAST) begin
                     st_d  = ST_WAIT_DONE;
                     tmr_d = '0;
                  end else begin
                     tmr_d = tmr_q + TMR_W'(1);
                  end
               end
               ST_WAIT_DONE: begin
                  // timeout has priority over a same-cycle reset_done
                  if (tmr_q == TMO_LAST) begin
                     st_d = ST_RETRY;
                  end else if (rx_reset_done_in[i]) begin
                     st_d  = ST_ALIGN;
                     tmr_d = '0;
                     cc_d  = '0;
                  end else begin
                     tmr_d = tmr_q + TMR_W'(1);
                  end
               end
               ST_ALIGN: begin
                  tmr_d = tmr_q + TMR_W'(1);
                  if (err)        cc_d = '0;
                  else if (comma) cc_d = cc_q + CC_W'(1);
                  if (tmr_q == TMO_LAST) begin
                     st_d = ST_RETRY;
                  end else if (!err && comma && cc_q == COMMA_LAST) begin
                     st_d  = ST_UP;
                     win_d = '0;
                     ec_d  = '0;
                  end
               end
               ST_UP: begin
                  win_d = win_q + WIN_W'(1);
                  ec_d  = ec_q + EC_W'(err);
                  if (rx_bufstatus_in[i] || (err && ec_q == THR_LAST)) begin
                     st_d = ST_RETRY;
                  end else if (win_q == WIN_LAST) begin
                     // window closed below threshold: lane proved healthy
                     win_d = '0;
                     ec_d  = '0;
                     rty_d = '0;
                  end
               end
               ST_RETRY: begin
                  if (rty_q == RTY_MAX) begin
                     st_d = ST_FAILED;
                  end else begin
                     st_d  = ST_RESET;
                     rty_d = rty_q + RTY_W'(1);
                     tmr_d = '0;
                  end
               end
               ST_FAILED: begin
                  st_d = ST_FAILED;
               end
               default: begin
                  st_d = ST_DISABLED;
               end
            endcase
         end
      end

      always_ff @(posedge rx_usrclk2_in) begin
         if (reset_all_in) begin
            st_q   <= ST_DISABLED;
            tmr_q  <= '0;
            rty_q  <= '0;
            cc_q   <= '0;
            win_q  <= '0;
            ec_q   <= '0;
            rst_q  <= 1'b1;
            up_q   <= 1'b0;
            fail_q <= 1'b0;
         end else begin
            st_q   <= st_d;
            tmr_q  <= tmr_d;
            rty_q  <= rty_d;
            cc_q   <= cc_d;
            win_q  <= win_d;
            ec_q   <= ec_d;
            rst_q  <= (st_d == ST_DISABLED) || (st_d == ST_RESET) ||
                      (st_d == ST_FAILED);
            up_q   <= (st_d == ST_UP);
            fail_q <= (st_d == ST_FAILED);
         end
      end

      always_ff @(posedge rx_usrclk2_in) begin
         if (reset_all_in || err_clear_in) begin
            cnt_q <= '0;
         end else if (st_q == ST_UP && err && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      assign up_now[i]                      = (st_q == ST_UP);
      assign rx_reset_datapath_out[i]       = rst_q;
      assign lane_up_out[i]                 = up_q;
      assign lane_failed_out[i]             = fail_q;
      assign err_count_out[i*CNT_W +: CNT_W] = cnt_q;
   end

   always_ff @(posedge rx_usrclk2_in) begin
      if (reset_all_in) begin
         link_q <= 1'b0;
      end else begin
         link_q <= (|lane_enable_in) && (&(up_now | ~lane_enable_in));
      end
   end

   assign link_up_out = link_q;

endmodule

// File: tb/tb_hssl_lane_manager.sv
// tb_hssl_lane_manager: scoreboard bench for hssl_lane_manager.
// Reference model tracks each lane as phase + time-in-phase counters.
module tb_hssl_lane_manager;

   localparam int N     = 4;
   localparam int COMMAS = 16;
   localparam int TMO   = 300;
   localparam int PULSE = 8;
   localparam int WIN   = 64;
   localparam int THR   = 8;
   localparam int MAXR  = 7;
   localparam int CW    = 5;
   localparam int CMAX  = 31;

   localparam int P_OFF   = 0;
   localparam int P_RST   = 1;
   localparam int P_WAIT  = 2;
   localparam int P_ALIGN = 3;
   localparam int P_UP    = 4;
   localparam int P_RETRY = 5;
   localparam int P_FAIL  = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [N-1:0]    en, done, comma, bufst;
   logic [4*N-1:0]  disp, enc;
   logic            clr;
   logic [N-1:0]    rdp, up, failed;
   logic            link;
   logic [CW*N-1:0] cnt;

   hssl_lane_manager #(
      .NUM_LANES(N), .ALIGN_COMMAS(COMMAS), .ALIGN_TIMEOUT(TMO),
      .RESET_PULSE(PULSE), .ERR_WINDOW(WIN), .ERR_THRESHOLD(THR),
      .MAX_RETRIES(MAXR), .CNT_W(CW)
   ) dut (
      .rx_usrclk2_in(clk),
      .reset_all_in(rst),
      .lane_enable_in(en),
      .rx_reset_done_in(done),
      .rx_commadet_in(comma),
      .rx_disperr_in(disp),
      .rx_encerr_in(enc),
      .rx_bufstatus_in(bufst),
      .err_clear_in(clr),
      .rx_reset_datapath_out(rdp),
      .lane_up_out(up),
      .lane_failed_out(failed),
      .link_up_out(link),
      .err_count_out(cnt)
   );

   typedef struct packed {
      logic [N-1:0]    rdp;
      logic [N-1:0]    up;
      logic [N-1:0]    fl;
      logic            link;
      logic [CW*N-1:0] cnt;
   } obs_t;

   obs_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   int ph[N], age[N], rtr[N], runc[N], werr[N], ecnt[N];
   bit link_m;

   function automatic void enter(input int l, input int p);
      ph[l]   = p;
      age[l]  = 0;
      runc[l] = 0;
      werr[l] = 0;
   endfunction

   function automatic void model_step();
      bit all_up;
      bit e;
      all_up = 1'b1;
      for (int l = 0; l < N; l++)
         if (en[l] && ph[l] != P_UP) all_up = 1'b0;
      if (rst) begin
         for (int l = 0; l < N; l++) begin
            enter(l, P_OFF);
            rtr[l]  = 0;
            ecnt[l] = 0;
         end
         link_m = 1'b0;
         return;
      end
      link_m = (|en) && all_up;
      for (int l = 0; l < N; l++) begin
         e = (|disp[4*l +: 4]) | (|enc[4*l +: 4]) | bufst[l];
         if (clr) ecnt[l] = 0;
         else if (ph[l] == P_UP && e && ecnt[l] < CMAX) ecnt[l]++;
         if (!en[l]) begin
            enter(l, P_OFF);
            rtr[l] = 0;
         end else begin
            case (ph[l])
               P_OFF: begin
                  enter(l, P_RST);
                  rtr[l] = 0;
               end
               P_RST:
                  if (age[l] + 1 >= PULSE) enter(l, P_WAIT);
                  else age[l]++;
               P_WAIT:
                  if (age[l] + 1 >= TMO) enter(l, P_RETRY);
                  else if (done[l]) enter(l, P_ALIGN);
                  else age[l]++;
               P_ALIGN: begin
                  if (e) runc[l] = 0;
                  else if (comma[l]) runc[l]++;
                  if (age[l] + 1 >= TMO) enter(l, P_RETRY);
                  else if (runc[l] >= COMMAS) enter(l, P_UP);
                  else age[l]++;
               end
               P_UP: begin
                  werr[l] += int'(e);
                  if (bufst[l] || werr[l] >= THR) enter(l, P_RETRY);
                  else begin
                     age[l]++;
                     if (age[l] % WIN == 0) begin
                        werr[l] = 0;
                        rtr[l]  = 0;
                     end
                  end
               end
               P_RETRY:
                  if (rtr[l] >= MAXR) enter(l, P_FAIL);
                  else begin
                     rtr[l]++;
                     enter(l, P_RST);
                  end
               default: ;
            endcase
         end
      end
   endfunction

   function automatic obs_t expect_now();
      obs_t o;
      o = '0;
      for (int l = 0; l < N; l++) begin
         o.rdp[l] = (ph[l] == P_OFF) || (ph[l] == P_RST) || (ph[l] == P_FAIL);
         o.up[l]  = (ph[l] == P_UP);
         o.fl[l]  = (ph[l] == P_FAIL);
         o.cnt[l*CW +: CW] = CW'(ecnt[l]);
      end
      o.link = link_m;
      return o;
   endfunction

   task automatic tick();
      model_step();
      sb.push_back(expect_now());
      @(negedge clk);
   endtask

   task automatic set_cycle(input int perr, input int pbuf, input int pcom);
      int b;
      disp = '0;
      enc  = '0;
      clr  = 1'b0;
      for (int l = 0; l < N; l++) begin
         comma[l] = int'($urandom_range(999)) < pcom;
         bufst[l] = int'($urandom_range(999)) < pbuf;
         if (int'($urandom_range(999)) < perr) begin
            b = int'($urandom_range(7));
            if (b < 4) disp[4*l + b] = 1'b1;
            else       enc[4*l + b - 4] = 1'b1;
         end
      end
   endtask

   task automatic inj(input int l);
      int b;
      b = int'($urandom_range(7));
      if (b < 4) disp[4*l + b] = 1'b1;
      else       enc[4*l + b - 4] = 1'b1;
   endtask

   task automatic run(input int n, input int perr, input int pbuf, input int pcom);
      for (int k = 0; k < n; k++) begin
         set_cycle(perr, pbuf, pcom);
         tick();
      end
   endtask

   initial begin : monitor
      obs_t e;
      obs_t g;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            g = {rdp, up, failed, link, cnt};
            checks++;
            if (g !== e) begin
               failures++;
               $display("FAIL cycle %0d outputs: got rdp=%b up=%b failed=%b link=%b cnt=%h, expected rdp=%b up=%b failed=%b link=%b cnt=%h",
                        cyc, g.rdp, g.up, g.fl, g.link, g.cnt,
                        e.rdp, e.up, e.fl, e.link, e.cnt);
            end
         end
      end
   end

   initial begin : stim
      int n;
      rst = 1'b1;
      en  = '0;
      done = '0;
      set_cycle(0, 0, 0);
      for (int l = 0; l < N; l++) begin
         enter(l, P_OFF);
         rtr[l]  = 0;
         ecnt[l] = 0;
      end
      link_m = 1'b0;
      run(3, 0, 0, 0);
      rst = 1'b0;

      // bring-up of lane 0, reset_done 10 cycles after enable
      en = 4'b0001;
      run(10, 0, 0, 1000);
      done[0] = 1'b1;
      run(40, 0, 0, 1000);

      // 8 error cycles inside a window force a retry
      n = 0;
      while (n < 8) begin
         set_cycle(0, 0, 1000);
         if ($urandom_range(2) == 0) begin
            inj(0);
            n++;
         end
         tick();
      end
      run(50, 0, 0, 1000);

      // 7 errors stay under threshold
      for (int k = 0; k < 7; k++) begin
         set_cycle(0, 0, 1000);
         inj(0);
         tick();
      end
      run(200, 0, 0, 1000);

      // reset_done never returns: timeouts until failure
      en[0] = 1'b0;
      run(1, 0, 0, 1000);
      done[0] = 1'b0;
      en[0] = 1'b1;
      run(8 * (TMO + PULSE + 1) + 20, 0, 0, 1000);
      en[0] = 1'b0;
      run(1, 0, 0, 1000);
      en[0] = 1'b1;
      done[0] = 1'b1;
      run(60, 0, 0, 1000);

      // drive lane 0 error counter into saturation
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 7; k++) begin
            set_cycle(0, 0, 1000);
            inj(0);
            tick();
         end
         run(WIN + 6, 0, 0, 1000);
      end
      for (int k = 0; k < 3; k++) begin
         set_cycle(0, 0, 1000);
         inj(0);
         tick();
      end
      set_cycle(0, 0, 1000);
      inj(0);
      clr = 1'b1;
      tick();
      run(5, 0, 0, 1000);

      // multi-lane link with lane 2 disabled
      en = 4'b1011;
      done = 4'b1111;
      run(60, 0, 0, 1000);
      en[1] = 1'b1;
      run(14, 0, 0, 1000);
      en[1] = 1'b0;
      run(20, 0, 0, 1000);
      rst = 1'b1;
      run(1, 0, 0, 1000);
      rst = 1'b0;
      run(40, 0, 0, 1000);

      // random soak
      for (int k = 0; k < 6000; k++) begin
         if ($urandom_range(999) < 3) en[$urandom_range(N-1)] ^= 1'b1;
         if ($urandom_range(999) < 5) done[$urandom_range(N-1)] ^= 1'b1;
         rst = ($urandom_range(1999) == 0);
         set_cycle(20, 2, 900);
         clr = ($urandom_range(999) < 3);
         tick();
      end
      rst = 1'b0;
      run(2, 0, 0, 1000);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
